universal_shift_register: RTL
=============================

// Module: universal_shift_register
// PURPOSE
//  Parametrised WIDTH-bit storage register for datapath staging.
//  Supports parallel load, clear, logical, arithmetic and rotate shifts by a multi-bit amount.
//  Commands arrive on a valid/ready handshake; multi-bit shifts execute one bit per clock under a small FSM.
//  It reports busy and done so a controller can sequence back-to-back operations.
// PARAMETERS
//  WIDTH    4   register / data width in bits (>=2)
//  SHAMT_W  3   width of cmd_amt; maximum shift amount is 2**SHAMT_W-1
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        block can accept a command (high only in IDLE)
//  cmd_op     in   3        000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 SRA, 101 ROTL, 110 ROTR, 111 CLEAR
//  cmd_amt    in   SHAMT_W  shift amount in bits (used by SHL/SHR/SRA/ROTL/ROTR only)
//  ser_in     in   1        fill bit for SHL (into LSB) and SHR (into MSB), sampled at every step
//  In         in   WIDTH    parallel load data
//  Out        out  WIDTH    register contents
//  ser_out    out  1        last bit shifted or rotated out
//  busy       out  1        shift in progress (state SHIFT)
//  done       out  1        one-cycle pulse: the accepted command has completed
// BEHAVIOUR
//  - Reset (reset==0, async): Out=0, ser_out=0, busy=0, done=0, state=IDLE. cmd_ready=1 once reset deasserts.
//  - Accept: a command is accepted at a rising edge where cmd_valid && cmd_ready.
//    - op, amt and the remaining-step count are latched there; In is sampled there; ser_in is sampled at each step.
//  - FSM states: IDLE, SHIFT.
//    - IDLE->SHIFT: a shift op is accepted with amt>0.
//    - SHIFT->IDLE: on the edge that performs the last step.
//  - NOP, LOAD, CLEAR, and any shift with amt==0:
//    - Out updates at the accept edge (LOAD: Out=In; CLEAR: Out=0; others: Out unchanged).
//    - State stays IDLE; done=1 in the following cycle.
//    - Back-to-back accepts every cycle are legal.
//  - Shift with amt=k>0:
//    - The accept edge does not change Out. Each of the next k edges performs one 1-bit step.
//    - busy=1, cmd_ready=0 for exactly k cycles.
//    - done=1 and cmd_ready=1 in the cycle after the k-th step.
//  - Step rules:
//    - SHL: Out={Out[W-2:0],ser_in}; ser_out=old MSB.
//    - SHR: Out={ser_in,Out[W-1:1]}; ser_out=old LSB.
//    - SRA: same as SHR but MSB refills with old MSB; ser_out=old LSB.
//    - ROTL / ROTR: rotate by one; ser_out=the wrapped bit.
//  - amt may exceed WIDTH: steps simply repeat.
//    - A rotate by WIDTH returns the original value.
//    - A logical shift by >=WIDTH leaves Out entirely filled from ser_in.
//  - ser_out changes only on shift steps. It holds through NOP/LOAD/CLEAR.
//  - done is registered, high for exactly one cycle per accepted command, and never high during reset.
//  - cmd_valid while cmd_ready==0 is ignored (not queued); the source holds the command until accepted.
//  - Reset asserted mid-shift aborts the command immediately: all outputs return to reset values and no done pulse is produced.
// CONFIGURATION
//  - USR_BARREL_EN defined:
//    - Every shift completes at the accept edge via a barrel shifter; state SHIFT is unused and busy is always 0.
//    - done=1 in the cycle after accept.
//    - Out and ser_out equal exactly the values the iterative path produces after k steps (same ser_in value used for every fill bit).
//  - USR_BARREL_EN undefined: iterative one-bit-per-cycle path as described above.
// TESTING (WIDTH=4, SHAMT_W=3)
//  - Drive reset=0 mid-run -> Out=0000, ser_out=0, busy=0, done=0 at once. After release, cmd_ready=1.
//  - LOAD In=1011 -> Out=1011 at the accept edge, done=1 for one cycle after. Repeat LOAD 0101 on the next cycle -> accepted, Out=0101.
//  - From 1011, SHL amt=2, ser_in=0:
//    - busy=1 for 2 cycles, Out 0110 then 1100, ser_out 1 then 0.
//    - done=1 next cycle; a cmd_valid driven while busy is ignored.
//  - From 1000, SRA amt=1 -> Out=1100, ser_out=0. From 1011, ROTR amt=5 -> Out=1101, ser_out=1, busy for 5 cycles.
//  - Start ROTL amt=7 on 1011, assert reset after 3 steps -> Out=0000, no done pulse, cmd_ready=1 after release.
//  - With USR_BARREL_EN: repeat the SHL/ROTR cases -> same Out/ser_out values, busy never 1, done exactly 1 cycle after accept.

Source files
------------

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   WIDTH-bit staging register with parallel load, clear, logical shifts,
//   arithmetic right shift and rotates by a multi-bit amount. Commands are
//   taken on a valid/ready handshake. By default a shift of k bits runs one
//   bit per clock under a two-state FSM (IDLE/SHIFT). A registered one-cycle
//   done pulse marks completion of every accepted command.
//
// Optional feature macro:
//   USR_BARREL_EN - when defined, every shift completes at the accept edge
//                   through an unrolled barrel network that produces exactly
//                   the result of k single-bit steps. SHIFT is never entered
//                   and busy stays 0.
//
// Parameters:
//   WIDTH    register / data width (>= 2)
//   SHAMT_W  width of cmd_amt; maximum shift amount is 2**SHAMT_W-1
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE only)
//   cmd_op     in   000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 SRA,
//                   101 ROTL, 110 ROTR, 111 CLEAR
//   cmd_amt    in   shift amount (shift ops only)
//   ser_in     in   fill bit for SHL (LSB) / SHR (MSB), sampled every step
//   In         in   parallel load data
//   Out        out  register contents
//   ser_out    out  last bit shifted or rotated out
//   busy       out  shift in progress
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [SHAMT_W-1:0] cmd_amt,
  input  logic               ser_in,
  input  logic [WIDTH-1:0]   In,
  output logic [WIDTH-1:0]   Out,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SRA   = 3'b100;
  localparam logic [2:0] OP_ROTL  = 3'b101;
  localparam logic [2:0] OP_ROTR  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ser_q, ser_d;
  logic               done_q, done_d;
  logic               accept_s;
  logic               shift_op_s;
  logic [WIDTH:0]     step_s;

  // One single-bit step. Result is {new ser_out, new register value}.
  // Non-shift opcodes leave both unchanged.
  function automatic logic [WIDTH:0] step_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic             s_old,
    input logic             fill
  );
    logic [WIDTH:0] r;
    r = {s_old, v};
    case (op)
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], fill};
      OP_SHR:  r = {v[0], fill, v[WIDTH-1:1]};
      OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROTL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROTR: r = {v[0], v[0], v[WIDTH-1:1]};
      default: r = {s_old, v};
    endcase
    return r;
  endfunction

`ifdef USR_BARREL_EN
  localparam int MAX_AMT = (1 << SHAMT_W) - 1;

  // Unrolled chain of single-bit steps, each stage enabled while its index
  // is below amt. Chaining the same step function guarantees bit-identical
  // Out/ser_out with the iterative path, including amt > WIDTH.
  function automatic logic [WIDTH:0] barrel_f(
    input logic [2:0]         op,
    input logic [SHAMT_W-1:0] amt,
    input logic [WIDTH-1:0]   v,
    input logic               s_old,
    input logic               fill
  );
    logic [WIDTH:0] r;
    r = {s_old, v};
    for (int i = 0; i < MAX_AMT; i++) begin
      if (SHAMT_W'(i) < amt) begin
        r = step_f(op, r[WIDTH-1:0], r[WIDTH], fill);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  assign accept_s   = cmd_valid && cmd_ready;
  assign shift_op_s = (cmd_op >= OP_SHL) && (cmd_op <= OP_ROTR);
  assign step_s     = step_f(op_q, out_q, ser_q, ser_in);

  // Next-state, datapath and done-pulse logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d = cmd_op;
          if (shift_op_s && (cmd_amt != {SHAMT_W{1'b0}})) begin
`ifdef USR_BARREL_EN
            {ser_d, out_d} = barrel_f(cmd_op, cmd_amt, out_q, ser_q, ser_in);
            done_d         = 1'b1;
`else
            // Accept edge only latches; the k steps follow on later edges.
            state_d = ST_SHIFT;
            cnt_d   = cmd_amt;
`endif
          end else begin
            // NOP, LOAD, CLEAR and zero-amount shifts finish right here;
            // ser_out is deliberately untouched.
            case (cmd_op)
              OP_LOAD:  out_d = In;
              OP_CLEAR: out_d = {WIDTH{1'b0}};
              default:  out_d = out_q;
            endcase
            done_d = 1'b1;
          end
        end else begin
          op_d = op_q;
        end
      end
      ST_SHIFT: begin
        {ser_d, out_d} = step_s;
        cnt_d          = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any shift without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= {SHAMT_W{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign Out       = out_q;
  assign ser_out   = ser_q;
  assign done      = done_q;

endmodule
